// File: rtl/counter_input_ctrl_pkg.sv
// Shared encodings and defaults for the counter input conditioning block.
package counter_input_ctrl_pkg;

  localparam logic [1:0] ST_PAUSE = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  localparam int DEB_CYCLES_DEF = 16;
  localparam int DIV_DEF        = 100;

  typedef struct packed {
    logic       en;
    logic       in;
    logic       dir;
    logic [3:0] data;
    logic       running;
  } ctrl_out_t;

endpackage

// File: rtl/counter_input_ctrl_if.sv
// Raw button in, one-cycle press pulse out, between the controller and a debouncer.
interface counter_input_ctrl_if;
  logic raw;
  logic pulse;

  modport deb  (input raw, output pulse);
  modport ctrl (output raw, input pulse);
endinterface

// File: rtl/counter_input_ctrl_btn_debounce.sv
// Two-flop synchronizer, stable-sample debounce and rising-edge press pulse for one button.
module btn_debounce
  import counter_input_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input logic               clk,
  input logic               rst_n,
  counter_input_ctrl_if.deb btn
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          level_prev_q, level_prev_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d      = btn.raw;
    sync2_d      = sync1_q;
    level_d      = level_q;
    cnt_d        = cnt_q;
    // any sample agreeing with the accepted level restarts the stability count
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    level_prev_d = level_q;
    pulse_d      = level_q & ~level_prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      pulse_q      <= pulse_d;
      cnt_q        <= cnt_d;
    end
  end

  assign btn.pulse = pulse_q;

endmodule

// File: rtl/counter_input_ctrl.sv
// Turns raw buttons/switches into registered en/in/dir/data strobes for the up/down load counter.
//   state    | meaning
//   PAUSE    | idle, no strobes, prescaler held at 0
//   RUN      | prescaler running, en strobe every DIV cycles
//   LOAD     | single cycle en=1,in=1, then back to PAUSE or RUN
module counter_input_ctrl
  import counter_input_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DIV        = DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_en,
  input  logic       btn_load,
  input  logic       sw_dir,
  input  logic [3:0] sw_data,
  output logic       en,
  output logic       in,
  output logic       dir,
  output logic [3:0] data,
  output logic       running
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  counter_input_ctrl_if en_btn_if ();
  counter_input_ctrl_if load_btn_if ();

  assign en_btn_if.raw   = btn_en;
  assign load_btn_if.raw = btn_load;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_en (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (en_btn_if)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (load_btn_if)
  );

  logic [4:0]    sw_s1_q, sw_s1_d;
  logic [4:0]    sw_s2_q, sw_s2_d;
  logic [1:0]    state_q, state_d;
  logic [1:0]    ret_q, ret_d;
  logic [PW-1:0] presc_q, presc_d;
  ctrl_out_t     out_q, out_d;

  always_comb begin
    sw_s1_d = {sw_dir, sw_data};
    sw_s2_d = sw_s1_q;
    state_d = state_q;
    ret_d   = ret_q;
    presc_d = '0;
    case (state_q)
      ST_PAUSE, ST_RUN: begin
        // a load press wins over a simultaneous run/pause press
        if (load_btn_if.pulse) begin
          state_d = ST_LOAD;
          ret_d   = state_q;
        end else if (en_btn_if.pulse) begin
          state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
        end else if (state_q == ST_RUN) begin
          presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end
      end
      ST_LOAD: state_d = ret_q;
      default: state_d = ST_PAUSE;
    endcase

    out_d         = out_q;
    out_d.dir     = sw_s2_q[4];
    out_d.running = (state_d == ST_RUN);
    out_d.in      = (state_d == ST_LOAD);
    out_d.en      = (state_d == ST_LOAD) || ((state_d == ST_RUN) && (presc_d == PRESC_LAST));
    if (state_d == ST_LOAD) begin
      out_d.data = sw_s2_q[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      state_q <= ST_PAUSE;
      ret_q   <= ST_PAUSE;
      presc_q <= '0;
      out_q   <= '0;
    end else begin
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
      state_q <= state_d;
      ret_q   <= ret_d;
      presc_q <= presc_d;
      out_q   <= out_d;
    end
  end

  assign en      = out_q.en;
  assign in      = out_q.in;
  assign dir     = out_q.dir;
  assign data    = out_q.data;
  assign running = out_q.running;

endmodule

// File: doc/counter_input_ctrl.md
COUNTER_INPUT_CTRL -- requirements
Module: counter_input_ctrl
(Upstream stage: conditions raw board buttons and switches into the en/in/dir/data controls of the 4-bit up/down load counter.)

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16, meaning consecutive stable samples required to accept a button level (>=1).
REQ-002 SHALL have parameter DIV, default 100, meaning clock cycles per count step in RUN (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port btn_en  input  1  raw run/pause pushbutton, active-high, asynchronous, bouncy.
REQ-006 SHALL have port btn_load  input  1  raw load pushbutton, active-high, asynchronous, bouncy.
REQ-007 SHALL have port sw_dir  input  1  raw direction switch (1 = up).
REQ-008 SHALL have port sw_data  input  4  raw load-value switches.
REQ-009 SHALL have port en  output  1  counter enable strobe.
REQ-010 SHALL have port in  output  1  counter load strobe, valid only with en=1.
REQ-011 SHALL have port dir  output  1  counter direction.
REQ-012 SHALL have port data  output  4  counter load value.
REQ-013 SHALL have port running  output  1  status: 1 in RUN.

Function
REQ-014 Every raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Each button SHALL be debounced: the debounced level changes only after DEB_CYCLES consecutive synchronized samples differ from it; any sample equal to the current debounced level clears the count.
REQ-016 A rising edge of a debounced button SHALL produce exactly one 1-cycle press pulse.
REQ-017 FSM states SHALL be PAUSE, RUN and LOAD; the reset state is PAUSE.
REQ-018 A btn_en pulse SHALL toggle PAUSE<->RUN.
REQ-019 A btn_load pulse in PAUSE or RUN SHALL enter LOAD for exactly one cycle, then return to the state it came from.
REQ-020 Simultaneous btn_load and btn_en pulses SHALL execute the load and discard the toggle.
REQ-021 In LOAD, outputs SHALL be en=1, in=1, data = synchronized sw_data sampled on the LOAD entry edge.
REQ-022 The prescaler, $clog2(DIV) bits wide, SHALL count 0..DIV-1 only in RUN and wrap to 0; it SHALL be held at 0 in PAUSE and cleared in LOAD.
REQ-023 In RUN, at prescaler value DIV-1, outputs SHALL be en=1, in=0 for one cycle; otherwise en=0.
REQ-024 In PAUSE, outputs SHALL be en=0, in=0.
REQ-025 in SHALL never be 1 while en=0.
REQ-026 dir SHALL be the registered synchronized sw_dir, updated every cycle regardless of state.
REQ-027 All outputs SHALL be registered.
REQ-028 Latency SHALL be fixed: with the first edge that samples a new stable raw button level counted as edge 1, the resulting strobe or running change SHALL be visible in the cycle after edge DEB_CYCLES+4.
REQ-029 data SHALL hold its last loaded value outside LOAD.

Reset
REQ-030 With rst_n=0 at a clock edge, all synchronizer flops, debounce counters and levels, the prescaler and the FSM (to PAUSE) SHALL clear, and en, in, dir, data and running SHALL be 0 from the next cycle.
REQ-031 Reset SHALL take precedence over any in-flight pulse, LOAD or strobe, and no press pulse SHALL be generated from the reset-cleared debounced level.

Structure
REQ-032 A shared package SHALL hold the state encodings (PAUSE=2'd0, RUN=2'd1, LOAD=2'd2) and the default DEB_CYCLES and DIV values.
REQ-033 The synchronizer, debounce and one-pulse logic SHALL be one sub-module, btn_debounce, instantiated once per button.

Verification (DEB_CYCLES=4, DIV=5)
REQ-034 rst_n=0 for 3 cycles with random buttons and switches -> en=in=running=dir=0 and data=0.
REQ-035 Clean btn_en press -> running=1 after 8 cycles, then en=1,in=0 every 5th cycle; a second press -> running=0 and no further en.
REQ-036 btn_load toggling every 2 cycles for 10 cycles then held 1, sw_data=4'b1010 -> exactly one cycle of en=1,in=1,data=1010, 8 cycles after the level becomes stable.
REQ-037 btn_en and btn_load pressed on the same cycle in PAUSE -> one load strobe, running stays 0.
REQ-038 Load in RUN with prescaler=3 -> load strobe, prescaler cleared, next step strobe 5 cycles after the LOAD cycle.
REQ-039 rst_n=0 for one cycle mid-RUN -> all outputs 0 next cycle; after release the block stays in PAUSE with no strobe.
